// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Transmit-side byte buffer and load sequencer for the uart transmitter.
//   Bytes pushed on clk are queued in a circular FIFO and handed to the
//   uart one at a time over a four-phase ld_tx_req/ld_tx_ack handshake.
//   A new byte is started only when the uart reports its transmitter empty.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   reset_n    in   asynchronous active-low reset
//   wr_en      in   push wr_data this cycle
//   wr_data    in   [7:0] byte to enqueue
//   flush      in   discard all queued bytes (one-cycle pulse)
//   clr_ovf    in   clear sticky overflow
//   full       out  FIFO holds 2**DEPTH_LOG2 bytes
//   count      out  [DEPTH_LOG2:0] bytes queued (byte in tx_data excluded)
//   overflow   out  sticky: a push was dropped
//   idle       out  FIFO empty, sequencer idle and uart transmitter empty
//   ld_tx_req  out  load request to uart
//   ld_tx_ack  in   uart acknowledge (uart clock domain, asynchronous)
//   tx_data    out  [7:0] byte presented to uart, stable through REQ/ACK
//   tx_empty   in   uart transmitter empty (uart clock domain, asynchronous)

module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  flush,
    input  logic                  clr_ovf,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  idle,
    output logic                  ld_tx_req,
    input  logic                  ld_tx_ack,
    output logic [7:0]            tx_data,
    input  logic                  tx_empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                req_nxt;
    logic                pop;
    logic                push;
    logic                drop;
    logic                fifo_empty;

    logic                ack_meta;
    logic                ack_s;
    logic                empty_meta;
    logic                empty_s;

    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [7:0]          mem [DEPTH];

    // Two-flop synchronisers; empty resets high so a freshly reset block
    // believes the uart is ready, matching an idle uart after power-up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_meta   <= 1'b0;
            ack_s      <= 1'b0;
            empty_meta <= 1'b1;
            empty_s    <= 1'b1;
        end else begin
            ack_meta   <= ld_tx_ack;
            ack_s      <= ack_meta;
            empty_meta <= tx_empty;
            empty_s    <= empty_meta;
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                        (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign count      = wr_ptr - rd_ptr;

    // A same-cycle pop frees a slot, so a push at full still lands.
    // A flush swallows any push offered alongside it.
    assign push = wr_en && !flush && (!full || pop);
    assign drop = wr_en && !flush && full && !pop;

    assign idle = fifo_empty && (state == ST_IDLE) && empty_s;

    always_comb begin
        state_nxt = state;
        req_nxt   = ld_tx_req;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                // !ack_s keeps us from starting while the uart is still
                // finishing the previous handshake.
                if (!fifo_empty && empty_s && !ack_s) begin
                    pop       = 1'b1;
                    req_nxt   = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!ack_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ld_tx_req <= 1'b0;
        end else begin
            state     <= state_nxt;
            ld_tx_req <= req_nxt;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // tx_data only changes on a pop, so it is stable for the whole handshake
    // even if the queue behind it is flushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data <= 8'h00;
        end else if (pop) begin
            tx_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        end
    end

    // A drop in the same cycle as clr_ovf wins, so no dropped byte goes unreported.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Randomised and directed bench for uart_tx_fifo with a queue-based
//   reference model and a uart model running on its own clock.

module tb_uart_tx_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic          clk       = 1'b0;
    logic          txclk     = 1'b0;
    logic          reset_n   = 1'b0;
    logic          wr_en     = 1'b0;
    logic [7:0]    wr_data   = 8'h00;
    logic          flush     = 1'b0;
    logic          clr_ovf   = 1'b0;
    logic          ld_tx_ack = 1'b0;
    logic          tx_empty  = 1'b1;
    logic          full;
    logic [DL:0]   count;
    logic          overflow;
    logic          idle;
    logic          ld_tx_req;
    logic [7:0]    tx_data;

    int checks = 0;
    int errors = 0;

    // uart model controls
    int ack_dly  = 3;
    int tx_time  = 6;
    bit rnd_uart = 1'b0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    // reference model state (reset values)
    logic [7:0] mq[$];
    int         m_phase = 0;      // 0 waiting, 1 requesting, 2 waiting for ack release
    logic       m_req   = 1'b0;
    logic [7:0] m_tx    = 8'h00;
    logic       m_ovf   = 1'b0;
    logic       m_am    = 1'b0;
    logic       m_as    = 1'b0;
    logic       m_em    = 1'b1;
    logic       m_es    = 1'b1;
    logic       m_pop;
    logic       m_full;
    logic       m_drop;

    uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .flush     (flush),
        .clr_ovf   (clr_ovf),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .idle      (idle),
        .ld_tx_req (ld_tx_req),
        .ld_tx_ack (ld_tx_ack),
        .tx_data   (tx_data),
        .tx_empty  (tx_empty)
    );

    // clk posedges at odd ns, txclk posedges at even ns: never coincident
    initial forever #5 clk = ~clk;
    initial forever #8 txclk = ~txclk;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endfunction

    function automatic logic m_idle();
        return (mq.size() == 0) && (m_phase == 0) && m_es;
    endfunction

    function automatic logic m_pop_next();
        return (m_phase == 0) && (mq.size() != 0) && m_es && !m_as;
    endfunction

    // Reference model: byte queue plus the handshake phases.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_phase = 0;
            m_req   = 1'b0;
            m_tx    = 8'h00;
            m_ovf   = 1'b0;
            m_am    = 1'b0;
            m_as    = 1'b0;
            m_em    = 1'b1;
            m_es    = 1'b1;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_pop  = m_pop_next();
            m_drop = 1'b0;
            if (m_pop) begin
                m_tx = mq.pop_front();
                exp_q.push_back(m_tx);
                m_req   = 1'b1;
                m_phase = 1;
            end else if (m_phase == 1 && m_as) begin
                m_req   = 1'b0;
                m_phase = 2;
            end else if (m_phase == 2 && !m_as) begin
                m_phase = 0;
            end
            if (flush) begin
                mq.delete();
            end else if (wr_en) begin
                if (!m_full || m_pop) mq.push_back(wr_data);
                else                  m_drop = 1'b1;
            end
            if (m_drop)       m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            m_as = m_am;
            m_am = ld_tx_ack;
            m_es = m_em;
            m_em = tx_empty;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("count",     int'(count),     mq.size());
        chk("full",      int'(full),      int'(mq.size() == DEPTH));
        chk("overflow",  int'(overflow),  int'(m_ovf));
        chk("ld_tx_req", int'(ld_tx_req), int'(m_req));
        chk("tx_data",   int'(tx_data),   int'(m_tx));
        chk("idle",      int'(idle),      int'(m_idle()));
    end

    // uart model on txclk: ack and drop tx_empty together, release ack after
    // req falls, then stay busy for the transmit time.
    initial begin
        int d;
        int t;
        int n;
        forever begin
            @(posedge txclk);
            if (ld_tx_req) begin
                if (rnd_uart) begin
                    d = $urandom_range(1, 12);
                    t = $urandom_range(1, 30);
                end else begin
                    d = ack_dly;
                    t = tx_time;
                end
                repeat (d) @(posedge txclk);
                if (ld_tx_req) begin
                    rx_q.push_back(tx_data);
                    ld_tx_ack = 1'b1;
                    tx_empty  = 1'b0;
                    n = 0;
                    while (ld_tx_req && n < 4000) begin
                        @(posedge txclk);
                        n++;
                    end
                    if (n >= 4000) begin
                        checks++;
                        errors++;
                        $display("FAIL uart_req_release: req still %0d expected 0 after %0d txclk", ld_tx_req, n);
                    end
                    ld_tx_ack = 1'b0;
                    repeat (t) @(posedge txclk);
                    tx_empty = 1'b1;
                end
            end
        end
    end

    // Drives inputs for one clk cycle; entered and left at posedge + 1.
    task automatic step(input logic we, input logic [7:0] d, input logic fl, input logic co);
        wr_en   = we;
        wr_data = d;
        flush   = fl;
        clr_ovf = co;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        flush   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int n = 0;
        while (!(idle && m_idle()) && n < maxc) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL %s: idle=%0d after %0d cycles, expected 1", nm, idle, n);
        end
    endtask

    task automatic check_stream(input string nm);
        int n;
        chk({nm, "_len"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({nm, "_byte"}, int'(rx_q[i]), int'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_req", int'(ld_tx_req), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_idle", int'(idle), 1);

        // single byte handshake
        ack_dly = 4;
        tx_time = 6;
        step(1'b1, 8'h41, 1'b0, 1'b0);
        chk("t2_req_after_write", int'(ld_tx_req), 0);
        chk("t2_count_after_write", int'(count), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t2_req_after_pop", int'(ld_tx_req), 1);
        chk("t2_tx_data", int'(tx_data), 8'h41);
        chk("t2_count_after_pop", int'(count), 0);
        n = 0;
        while (ld_tx_req && n < 500) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        chk("t2_req_fell", int'(ld_tx_req), 0);
        chk("t2_ack_at_req_fall", int'(ld_tx_ack), 1);
        wait_idle(2000, "t2_idle");
        chk("t2_rx_len", rx_q.size(), 1);
        if (rx_q.size() == 1) chk("t2_rx_byte", int'(rx_q[0]), 8'h41);
        check_stream("t2_stream");

        // fill to full with a slow uart, then overflow
        ack_dly = 200;
        tx_time = 20;
        for (int i = 1; i <= 18; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 2) begin
                chk("t3_first_req", int'(ld_tx_req), 1);
                chk("t3_first_byte", int'(tx_data), 8'h01);
            end
            if (i == 16) begin
                chk("t3_count15", int'(count), 15);
                chk("t3_not_full", int'(full), 0);
            end
            if (i == 17) begin
                chk("t3_count16", int'(count), 16);
                chk("t3_full", int'(full), 1);
                chk("t3_no_ovf_yet", int'(overflow), 0);
            end
        end
        chk("t3_overflow", int'(overflow), 1);
        chk("t3_count_after_drop", int'(count), 16);

        // clear racing a dropped push, then clear alone
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("t6_set_beats_clr", int'(overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t6_clr", int'(overflow), 0);

        // push at full in the exact cycle of a pop
        n = 0;
        while (!m_pop_next() && n < 3000) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        chk("t4_pop_reached", int'(m_pop_next()), 1);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("t4_count", int'(count), 16);
        chk("t4_full", int'(full), 1);
        chk("t4_overflow", int'(overflow), 0);
        chk("t4_req", int'(ld_tx_req), 1);
        ack_dly = 3;
        tx_time = 5;
        wait_idle(8000, "t4_idle");
        chk("t4_rx_len", rx_q.size(), 18);
        if (rx_q.size() == 18) begin
            for (int i = 0; i < 17; i++) chk("t4_rx_order", int'(rx_q[i]), i + 1);
            chk("t4_rx_last", int'(rx_q[17]), 8'hA5);
        end
        check_stream("t4_stream");

        // flush while the first byte is in REQ
        ack_dly = 40;
        tx_time = 10;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h51 + i), 1'b0, 1'b0);
        chk("t5_req", int'(ld_tx_req), 1);
        chk("t5_count_before", int'(count), 4);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_count_after", int'(count), 0);
        chk("t5_req_kept", int'(ld_tx_req), 1);
        chk("t5_tx_data_kept", int'(tx_data), 8'h51);
        wait_idle(3000, "t5_idle");
        chk("t5_idle", int'(idle), 1);
        chk("t5_rx_len", rx_q.size(), 1);
        if (rx_q.size() == 1) chk("t5_rx_byte", int'(rx_q[0]), 8'h51);
        check_stream("t5_stream");

        // randomised traffic
        rnd_uart = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 15) == 0));
        end
        wait_idle(20000, "rnd_idle");
        check_stream("rnd_stream");
        rnd_uart = 1'b0;

        // asynchronous reset in the middle of a request
        ack_dly = 150;
        tx_time = 10;
        for (int i = 0; i < 18; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        chk("t1_req_before", int'(ld_tx_req), 1);
        chk("t1_ovf_before", int'(overflow), 1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t1_async_req", int'(ld_tx_req), 0);
        chk("t1_async_count", int'(count), 0);
        chk("t1_async_ovf", int'(overflow), 0);
        chk("t1_async_full", int'(full), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t1_idle_after", int'(idle), 1);
        repeat (300) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t1_no_req", int'(ld_tx_req), 0);
        chk("t1_rx_none", rx_q.size(), 0);
        rx_q.delete();
        exp_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
